// File: rtl/seg_pkg.sv
// Types and constants shared by the 7-segment encoder and the scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned BUS_W      = SEG_W * NUM_DIGITS;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   localparam logic [SEG_W-1:0] DIGIT_PAT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // Indexed by digit number; digit 0 (leftmost) drives an[3].
   localparam logic [NUM_DIGITS-1:0] AN_ONEHOT [NUM_DIGITS] = '{
      4'b1000, 4'b0100, 4'b0010, 4'b0001
   };

   typedef logic [1:0] digit_idx_t;

   typedef struct packed {
      logic [BUS_W-1:0]      seg;
      logic [NUM_DIGITS-1:0] dp;
      logic [NUM_DIGITS-1:0] blink;
   } frame_t;

   function automatic logic [SEG_W-1:0] pick_digit(input logic [BUS_W-1:0] bus,
                                                   input digit_idx_t       idx);
      logic [SEG_W-1:0] d;
      case (idx)
         2'd0:    d = bus[27:21];
         2'd1:    d = bus[20:14];
         2'd2:    d = bus[13:7];
         default: d = bus[6:0];
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pulse_divider.sv
// Free-running modulo-DIV counter; o_tc is high during the terminal-count cycle.
// Synchronous active-low reset.
module pulse_divider #(
   parameter int unsigned DIV = 4
) (
   input  logic i_clk,
   input  logic i_resetn,
   output logic o_tc
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] r_cnt;

   assign o_tc = (r_cnt == W'(DIV - 1));

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_cnt <= '0;
      end else if (o_tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexes four framed 7-segment digits onto one segment bus with per-digit
// blink and decimal point, global blank and anti-ghosting dead time.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 25000000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_resetn,
   input  logic [BUS_W-1:0]      i_seg_in,
   input  logic [NUM_DIGITS-1:0] i_blink_mask,
   input  logic [NUM_DIGITS-1:0] i_dp_mask,
   input  logic                  i_blank,
   output logic [NUM_DIGITS-1:0] o_an,
   output logic [SEG_W-1:0]      o_seg_out,
   output logic                  o_dp_out,
   output logic [1:0]            o_digit_idx,
   output logic                  o_frame_tick
);

   localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;
   localparam logic [SEG_W-1:0]      SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
   localparam logic                  DP_OFF  = ACTIVE_LOW;

   logic                  w_pre_tc;
   logic                  w_blink_tc;
   logic                  w_wrap;
   logic                  w_off;
   logic                  w_blink_bit;
   logic [NUM_DIGITS-1:0] w_an_hi;
   logic [SEG_W-1:0]      w_seg_hi;
   logic                  w_dp_hi;
   frame_t                w_frame_in;
   frame_t                w_frame_use;

   digit_idx_t            r_idx;
   logic                  r_phase;
   logic                  r_load;
   logic                  r_tick;
   frame_t                r_frame;
   logic [NUM_DIGITS-1:0] r_an;
   logic [SEG_W-1:0]      r_seg;
   logic                  r_dp;

   pulse_divider #(
      .DIV (REFRESH_DIV)
   ) u_prescaler (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .o_tc     (w_pre_tc)
   );

   pulse_divider #(
      .DIV (BLINK_DIV)
   ) u_blink_div (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .o_tc     (w_blink_tc)
   );

   assign w_wrap = w_pre_tc && (r_idx == 2'd3);

   always_comb begin
      w_frame_in.seg   = i_seg_in;
      w_frame_in.dp    = i_dp_mask;
      w_frame_in.blink = i_blink_mask;
      // The first slot after reset shows the frame being loaded, not the cleared one.
      w_frame_use = r_load ? w_frame_in : r_frame;
   end

   always_comb begin
      w_blink_bit = w_frame_use.blink[~r_idx];
      w_off       = w_pre_tc || i_blank || (w_blink_bit && r_phase);
      w_an_hi     = w_off ? '0 : AN_ONEHOT[r_idx];
      w_seg_hi    = w_off ? SEG_BLANK : pick_digit(w_frame_use.seg, r_idx);
      w_dp_hi     = !w_off && w_frame_use.dp[~r_idx];
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_idx   <= '0;
         r_phase <= 1'b0;
         r_load  <= 1'b1;
         r_tick  <= 1'b0;
         r_frame <= '0;
         r_an    <= AN_OFF;
         r_seg   <= SEG_OFF;
         r_dp    <= DP_OFF;
      end else begin
         if (w_pre_tc) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_blink_tc) begin
            r_phase <= ~r_phase;
         end
         if (r_load || w_wrap) begin
            r_frame <= w_frame_in;
         end
         r_load <= 1'b0;
         r_tick <= w_wrap;
         r_an   <= w_an_hi ^ AN_OFF;
         r_seg  <= w_seg_hi ^ SEG_OFF;
         r_dp   <= w_dp_hi ^ DP_OFF;
      end
   end

   assign o_an         = r_an;
   assign o_seg_out    = r_seg;
   assign o_dp_out     = r_dp;
   assign o_digit_idx  = r_idx;
   assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios and random traffic checked every
// cycle against an arithmetic model keyed on the number of edges since reset.
module tb_seg_scan_driver;
   import seg_pkg::*;

   localparam int R = 4;
   localparam int B = 16;

   logic        clk = 1'b0;
   logic        resetn;
   logic [27:0] seg_in;
   logic [3:0]  blink_mask;
   logic [3:0]  dp_mask;
   logic        blank;
   logic [3:0]  an;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;

   // Model state: edges since reset and the frame currently latched.
   int          n = 0;
   logic [27:0] m_seg = '0;
   logic [3:0]  m_dp = '0;
   logic [3:0]  m_blink = '0;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [1:0]  e_idx;
   logic        e_tick;

   logic [3:0] an_lit [16] = '{4'h7, 4'h7, 4'h7, 4'hF, 4'hB, 4'hB, 4'hB, 4'hF,
                               4'hD, 4'hD, 4'hD, 4'hF, 4'hE, 4'hE, 4'hE, 4'hF};
   logic [6:0] seg_lit [16] = '{7'h40, 7'h40, 7'h40, 7'h7F, 7'h79, 7'h79, 7'h79, 7'h7F,
                                7'h24, 7'h24, 7'h24, 7'h7F, 7'h30, 7'h30, 7'h30, 7'h7F};

   always #5 clk = ~clk;

   seg_scan_driver #(
      .REFRESH_DIV (R),
      .BLINK_DIV   (B),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .i_clk        (clk),
      .i_resetn     (resetn),
      .i_seg_in     (seg_in),
      .i_blink_mask (blink_mask),
      .i_dp_mask    (dp_mask),
      .i_blank      (blank),
      .o_an         (an),
      .o_seg_out    (seg_out),
      .o_dp_out     (dp_out),
      .o_digit_idx  (digit_idx),
      .o_frame_tick (frame_tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t, n=%0d)", name, act, exp, $time, n);
      end
   endtask

   // One clock edge: update the model from the inputs seen at the edge, then compare.
   task automatic step();
      logic [27:0] s;
      logic [3:0]  bm, dm, an_hi;
      logic [6:0]  seg_hi;
      logic        bl, rn, off, dp_hi;
      int          p, pre, idx, phase;
      s = seg_in; bm = blink_mask; dm = dp_mask; bl = blank; rn = resetn;
      @(posedge clk);
      if (!rn) begin
         n = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0; e_tick = 1'b0;
      end else begin
         n++;
         if (n == 1) begin
            m_seg = s; m_dp = dm; m_blink = bm;
         end
         p     = n - 1;
         pre   = p % R;
         idx   = (p / R) % 4;
         phase = (p / B) % 2;
         off   = (pre == R - 1) || bl || (m_blink[3-idx] && phase == 1);
         an_hi = off ? 4'h0 : 4'(1 << (3 - idx));
         seg_hi = off ? 7'h00 : m_seg[(3-idx)*7 +: 7];
         dp_hi = !off && m_dp[3-idx];
         e_an   = ~an_hi;
         e_seg  = ~seg_hi;
         e_dp   = ~dp_hi;
         e_idx  = 2'((n / R) % 4);
         e_tick = (n % (4 * R)) == 0;
         if ((n % (4 * R)) == 0) begin
            m_seg = s; m_dp = dm; m_blink = bm;
         end
      end
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg_out", 32'(seg_out), 32'(e_seg));
      check("dp_out", 32'(dp_out), 32'(e_dp));
      check("digit_idx", 32'(digit_idx), 32'(e_idx));
      check("frame_tick", 32'(frame_tick), 32'(e_tick));
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic wait_idx(input logic [1:0] v);
      for (int i = 0; i < 64 && digit_idx != v; i++) step();
      check("wait_digit_idx", 32'(digit_idx), 32'(v));
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 64 && frame_tick !== 1'b1; i++) step();
      check("wait_frame_tick", 32'(frame_tick), 32'd1);
   endtask

   initial begin
      resetn     = 1'b0;
      seg_in     = {DIGIT_PAT[0], DIGIT_PAT[1], DIGIT_PAT[2], DIGIT_PAT[3]};
      blink_mask = 4'b0000;
      dp_mask    = 4'b0000;
      blank      = 1'b0;
      run(3);
      check("reset_an", 32'(an), 32'hF);
      check("reset_seg", 32'(seg_out), 32'h7F);
      check("reset_dp", 32'(dp_out), 32'h1);
      check("reset_idx", 32'(digit_idx), 32'h0);
      check("reset_tick", 32'(frame_tick), 32'h0);

      // Plain scan pinned against a hand-computed trace.
      resetn = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         check("lit_an", 32'(an), 32'(an_lit[k]));
         check("lit_seg", 32'(seg_out), 32'(seg_lit[k]));
         check("lit_tick", 32'(frame_tick), (k == 15) ? 32'd1 : 32'd0);
      end

      // Mid-frame input change must wait for the next frame.
      wait_idx(2'd1);
      seg_in = {4{7'h7F}};
      step();
      check("tear_free_d1", 32'(seg_out), 32'h79);
      wait_tick();
      step();
      check("new_frame_d0", 32'(seg_out), 32'h00);
      run(16);

      blink_mask = 4'b0001;
      seg_in     = {DIGIT_PAT[4], DIGIT_PAT[5], DIGIT_PAT[6], DIGIT_PAT[7]};
      run(80);

      blink_mask = 4'b0000;
      dp_mask    = 4'b1000;
      run(32);
      blank = 1'b1;
      run(6);
      check("blank_an", 32'(an), 32'hF);
      blank = 1'b0;
      run(12);

      // Mid-scan reset.
      wait_idx(2'd2);
      resetn = 1'b0;
      step();
      check("midreset_an", 32'(an), 32'hF);
      check("midreset_idx", 32'(digit_idx), 32'h0);
      resetn = 1'b1;
      run(20);

      for (int i = 0; i < 1500; i++) begin
         seg_in = 28'($urandom);
         if ($urandom_range(7) == 0) dp_mask = 4'($urandom);
         if ($urandom_range(7) == 0) blink_mask = 4'($urandom);
         blank  = ($urandom_range(9) == 0);
         resetn = ($urandom_range(199) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
